// File: rtl/mask_thumb_overlay.sv
// Decimated mask thumbnail capture into a ping-pong bit buffer,
// overlaid onto the outgoing RGB565 stream two cycles later.
module mask_thumb_overlay #(
   parameter int H_ACT = 800,
   parameter int V_ACT = 480,
   parameter int DECIM = 2,
   parameter int OX = 0,
   parameter int OY = 0,
   parameter logic [15:0] FG_COLOR = 16'hFFFF,
   parameter logic [15:0] BG_COLOR = 16'h0000,
   localparam int TW = H_ACT / DECIM,
   localparam int TH = V_ACT / DECIM,
   localparam int NPIX = TW * TH,
   localparam int CW = $clog2(NPIX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pre_frame_vsync,
   input  logic          pre_frame_href,
   input  logic          pre_frame_de,
   input  logic [15:0]   pre_rgb,
   input  logic          pre_mask,
   input  logic [1:0]    mode,
   input  logic          freeze,
   output logic          post_frame_vsync,
   output logic          post_frame_href,
   output logic          post_frame_de,
   output logic [15:0]   post_rgb,
   output logic          frame_done,
   output logic [CW-1:0] mask_count
);

   localparam int XW = $clog2(H_ACT + 1);
   localparam int YW = $clog2(V_ACT + 1);
   localparam int AW = $clog2(2 * NPIX);
   localparam int LD = $clog2(DECIM);

   localparam logic [XW-1:0] X_END = XW'(H_ACT);
   localparam logic [YW-1:0] Y_END = YW'(V_ACT);
   localparam logic [XW-1:0] X_M   = XW'(DECIM - 1);
   localparam logic [YW-1:0] Y_M   = YW'(DECIM - 1);
   localparam logic [XW-1:0] X_LO  = XW'(OX);
   localparam logic [XW-1:0] X_HI  = XW'(OX + TW);
   localparam logic [YW-1:0] Y_LO  = YW'(OY);
   localparam logic [YW-1:0] Y_HI  = YW'(OY + TH);

   if (OX + TW > H_ACT || OY + TH > V_ACT) begin : g_bad_geom
      $error("overlay does not fit inside the active area");
   end
   if (DECIM != 1 && DECIM != 2 && DECIM != 4 && DECIM != 8) begin : g_bad_decim
      $error("DECIM must be 1, 2, 4 or 8");
   end

   logic          vsync_d1;
   logic          href_d1;
   logic          seen_de;
   logic          armed;
   logic          wbank;
   logic          rbank;
   logic          valid;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CW-1:0] accum;
   logic [1:0]    mode_l;

   logic          vs_rise;
   logic          de_v;
   logic          hr_fall;
   logic          swap;
   logic          sample;
   logic          in_reg;
   logic          wbank_cur;
   logic          rbank_cur;
   logic          valid_cur;
   logic [1:0]    mode_cur;
   logic [XW-1:0] x_cur;
   logic [YW-1:0] y_cur;
   logic [AW-1:0] waddr;
   logic [AW-1:0] raddr;

   logic          mem [2*NPIX];
   logic          rbit;

   logic [15:0]   rgb_s1;
   logic          mask_s1;
   logic          vs_s1;
   logic          hr_s1;
   logic          de_s1;
   logic          reg_s1;
   logic [1:0]    mode_s1;

   logic [15:0]   dim;
   logic [15:0]   mux_rgb;

   // A pixel coincident with vs_rise belongs to the new frame at (0,0).
   always_comb begin
      vs_rise   = pre_frame_vsync & ~vsync_d1;
      de_v      = pre_frame_de & pre_frame_href;
      hr_fall   = href_d1 & ~pre_frame_href & seen_de;
      x_cur     = vs_rise ? '0 : x;
      y_cur     = vs_rise ? '0 : y;
      swap      = vs_rise & armed & (y == Y_END) & ~freeze;
      wbank_cur = wbank ^ swap;
      rbank_cur = rbank ^ swap;
      valid_cur = valid | swap;
      mode_cur  = vs_rise ? mode : mode_l;
   end

   always_comb begin
      sample = (armed | vs_rise) & de_v
             & (x_cur < X_END) & (y_cur < Y_END)
             & ((x_cur & X_M) == X_M)
             & ((y_cur & Y_M) == Y_M);
      in_reg = (x_cur >= X_LO) & (x_cur < X_HI)
             & (y_cur >= Y_LO) & (y_cur < Y_HI);
      waddr  = (wbank_cur ? AW'(NPIX) : '0)
             + AW'(y_cur >> LD) * AW'(TW)
             + AW'(x_cur >> LD);
      raddr  = (rbank_cur ? AW'(NPIX) : '0)
             + AW'(y_cur - Y_LO) * AW'(TW)
             + AW'(x_cur - X_LO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_d1 <= 1'b0;
         href_d1  <= 1'b0;
         seen_de  <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else begin
         vsync_d1 <= pre_frame_vsync;
         href_d1  <= pre_frame_href;
         seen_de  <= pre_frame_href & ((seen_de & ~vs_rise) | de_v);
         if (!pre_frame_href)
            x <= '0;
         else if (de_v && x_cur != X_END)
            x <= x_cur + 1'b1;
         else
            x <= x_cur;
         if (vs_rise)
            y <= '0;
         else if (hr_fall && y != Y_END)
            y <= y + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         armed      <= 1'b0;
         wbank      <= 1'b0;
         rbank      <= 1'b1;
         valid      <= 1'b0;
         accum      <= '0;
         mode_l     <= 2'd0;
         mask_count <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= swap;
         if (vs_rise) begin
            armed  <= 1'b1;
            mode_l <= mode;
         end
         if (swap) begin
            wbank      <= ~wbank;
            rbank      <= ~rbank;
            valid      <= 1'b1;
            mask_count <= accum;
         end
         if (vs_rise)
            accum <= (sample & pre_mask) ? CW'(1) : '0;
         else if (sample & pre_mask)
            accum <= accum + 1'b1;
      end
   end

   // Bit buffer: no reset, one-cycle registered read.
   always_ff @(posedge clk) begin
      if (sample)
         mem[waddr] <= pre_mask;
      rbit <= mem[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rgb_s1  <= '0;
         mask_s1 <= 1'b0;
         vs_s1   <= 1'b0;
         hr_s1   <= 1'b0;
         de_s1   <= 1'b0;
         reg_s1  <= 1'b0;
         mode_s1 <= 2'd0;
      end else begin
         rgb_s1  <= pre_rgb;
         mask_s1 <= pre_mask;
         vs_s1   <= pre_frame_vsync;
         hr_s1   <= pre_frame_href;
         de_s1   <= pre_frame_de;
         reg_s1  <= in_reg & valid_cur;
         mode_s1 <= mode_cur;
      end
   end

   always_comb begin
      dim = {1'b0, rgb_s1[15:12],
             1'b0, rgb_s1[10:6],
             1'b0, rgb_s1[4:1]};
      unique case (mode_s1)
         2'd0: mux_rgb = rgb_s1;
         2'd1: mux_rgb = reg_s1 ? (rbit ? FG_COLOR : BG_COLOR) : rgb_s1;
         2'd2: mux_rgb = reg_s1 ? (rbit ? FG_COLOR : dim) : rgb_s1;
         default: mux_rgb = mask_s1 ? FG_COLOR : BG_COLOR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         post_frame_vsync <= 1'b0;
         post_frame_href  <= 1'b0;
         post_frame_de    <= 1'b0;
         post_rgb         <= '0;
      end else begin
         post_frame_vsync <= vs_s1;
         post_frame_href  <= hr_s1;
         post_frame_de    <= de_s1;
         post_rgb         <= mux_rgb;
      end
   end

endmodule

// File: tb/tb_mask_thumb_overlay.sv
// Directed frame sequence against a frame-level thumbnail model;
// pixel expectations are queued at drive time and popped two cycles later.
module tb_mask_thumb_overlay;

   localparam int H = 16;
   localparam int V = 8;
   localparam int D = 2;
   localparam int OX = 4;
   localparam int OY = 2;
   localparam int TW = H / D;
   localparam int TH = V / D;
   localparam logic [15:0] FG = 16'hFFE0;
   localparam logic [15:0] BG = 16'h0821;
   localparam int ALL1 = 0;
   localparam int EVENX = 1;
   localparam int CHECK = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        vs, hr, de;
   logic [15:0] rgb;
   logic        mk;
   logic [1:0]  mode;
   logic        freeze;
   logic        o_vs, o_hr, o_de;
   logic [15:0] o_rgb;
   logic        fdone;
   logic [5:0]  mcount;

   mask_thumb_overlay #(
      .H_ACT(H), .V_ACT(V), .DECIM(D), .OX(OX), .OY(OY),
      .FG_COLOR(FG), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst),
      .pre_frame_vsync(vs), .pre_frame_href(hr), .pre_frame_de(de),
      .pre_rgb(rgb), .pre_mask(mk), .mode(mode), .freeze(freeze),
      .post_frame_vsync(o_vs), .post_frame_href(o_hr),
      .post_frame_de(o_de), .post_rgb(o_rgb),
      .frame_done(fdone), .mask_count(mcount)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;
   logic [18:0] q[$];

   bit         m_armed = 0;
   bit         m_valid = 0;
   int         m_disp = 0;
   int         m_wpat = 0;
   int         m_lines = 0;
   int         m_count = 0;
   logic [1:0] m_mode = 2'd0;

   function automatic logic mpat(int p, int x, int y);
      case (p)
         ALL1:  return 1'b1;
         EVENX: return (x % 2) == 0;
         default: return ((x / 2 + y / 2) % 2) == 1;
      endcase
   endfunction

   function automatic logic [15:0] rpat(int s, int x, int y);
      if (s != 0) return 16'hFFFF;
      return 16'((x * 2113) ^ (y * 8448) ^ 23100);
   endfunction

   function automatic int cnt(int p);
      int n = 0;
      for (int yy = 0; yy < V; yy++)
         for (int xx = 0; xx < H; xx++)
            if (xx % D == D - 1 && yy % D == D - 1 && mpat(p, xx, yy))
               n++;
      return n;
   endfunction

   function automatic logic [15:0] exp_rgb(int x, int y,
                                           logic [15:0] c, logic m);
      logic inr;
      logic b;
      logic [15:0] dim;
      inr = m_valid && x >= OX && x < OX + TW && y >= OY && y < OY + TH;
      b = mpat(m_disp, D * (x - OX) + D - 1, D * (y - OY) + D - 1);
      dim = {c[15:11] >> 1, c[10:5] >> 1, c[4:0] >> 1};
      case (m_mode)
         2'd0: return c;
         2'd1: return inr ? (b ? FG : BG) : c;
         2'd2: return inr ? (b ? FG : dim) : c;
         default: return m ? FG : BG;
      endcase
   endfunction

   task automatic cyc(input logic v, input logic h, input logic d,
                      input logic [15:0] c, input logic m,
                      input int x, input int y, input logic fd);
      logic [18:0] e;
      logic [18:0] got;
      @(negedge clk);
      vs = v; hr = h; de = d; rgb = c; mk = m;
      q.push_back({v, h, d, exp_rgb(x, y, c, m)});
      @(posedge clk);
      #1;
      if (q.size() == 2) begin
         e = q.pop_front();
         got = {o_vs, o_hr, o_de, o_rgb};
         vecs++;
         assert (got === e) else begin
            errs++;
            $error("FAIL pix got %h exp %h", got, e);
         end
      end
      vecs++;
      assert (fdone === fd) else begin
         errs++;
         $error("FAIL frame_done got %b exp %b", fdone, fd);
      end
      vecs++;
      assert (mcount === 6'(m_count)) else begin
         errs++;
         $error("FAIL mask_count got %0d exp %0d", mcount, m_count);
      end
   endtask

   task automatic frame(input int pat, input int rsel, input int nl,
                        input logic [1:0] md, input logic [1:0] md_mid,
                        input logic frz);
      logic fd;
      mode = md;
      freeze = frz;
      fd = m_armed && m_lines == V && !frz;
      if (fd) begin
         m_disp = m_wpat;
         m_count = cnt(m_wpat);
         m_valid = 1;
      end
      m_armed = 1;
      m_mode = md;
      m_wpat = pat;
      m_lines = nl;
      cyc(1, 0, 0, 16'h0, 0, 0, 0, fd);
      cyc(1, 0, 0, 16'h0, 0, 0, 0, 0);
      cyc(0, 0, 0, 16'h0, 0, 0, 0, 0);
      for (int l = 0; l < nl; l++) begin
         if (l == 4) mode = md_mid;
         for (int x = 0; x < H; x++)
            cyc(0, 1, 1, rpat(rsel, x, l), mpat(pat, x, l), x, l, 0);
         cyc(0, 0, 0, 16'h0, 0, 0, l + 1, 0);
         cyc(0, 0, 0, 16'h0, 0, 0, l + 1, 0);
      end
   endtask

   initial begin
      rst = 1'b1;
      vs = 0; hr = 0; de = 0; rgb = '0; mk = 0;
      mode = 2'd1; freeze = 0;
      repeat (3) @(posedge clk);
      #1;
      vecs++;
      assert ({o_vs, o_hr, o_de, o_rgb} === 19'h0) else begin
         errs++;
         $error("FAIL rst_post got %h exp 0", {o_vs, o_hr, o_de, o_rgb});
      end
      vecs++;
      assert (fdone === 1'b0) else begin
         errs++;
         $error("FAIL rst_fdone got %b exp 0", fdone);
      end
      vecs++;
      assert (mcount === 6'd0) else begin
         errs++;
         $error("FAIL rst_count got %0d exp 0", mcount);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) cyc(0, 0, 0, 16'h0, 0, 0, 0, 0);

      frame(ALL1,  0, 8, 2'd1, 2'd1, 0);
      frame(ALL1,  0, 8, 2'd1, 2'd1, 0);
      frame(EVENX, 0, 8, 2'd1, 2'd1, 0);
      frame(EVENX, 0, 8, 2'd1, 2'd1, 0);
      frame(ALL1,  1, 8, 2'd2, 2'd2, 0);
      frame(EVENX, 0, 5, 2'd1, 2'd1, 0);
      frame(CHECK, 0, 8, 2'd1, 2'd1, 0);
      frame(EVENX, 0, 8, 2'd1, 2'd1, 1);
      frame(CHECK, 0, 8, 2'd1, 2'd1, 1);
      frame(ALL1,  0, 8, 2'd1, 2'd3, 0);
      frame(CHECK, 0, 8, 2'd3, 2'd3, 0);
      repeat (3) cyc(0, 0, 0, 16'h0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mask_thumb_overlay.md
# mask_thumb_overlay

Parametrised successor to the fixed 800x480 mask-thumbnail path. It takes the pixel stream and its aligned 1-bit colour-threshold mask, and decimates the mask by DECIM into a ping-pong on-chip bit buffer. It overlays the last complete frame's thumbnail onto the outgoing RGB565 stream at a programmable position. Everything runs on the single pixel clock: no data-enable-derived clocks.

## Interface
Parameters:
- H_ACT, 800, active pixels per line
- V_ACT, 480, active lines per frame
- DECIM, 2, decimation factor; one of 1, 2, 4, 8
- OX, 0, overlay left column
- OY, 0, overlay top line
- FG_COLOR, 16'hFFFF, RGB565 colour for mask bit 1
- BG_COLOR, 16'h0000, RGB565 colour for mask bit 0

Derived values: TW = H_ACT/DECIM, TH = V_ACT/DECIM, NPIX = TW*TH. Elaboration fails unless OX+TW <= H_ACT and OY+TH <= V_ACT.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pre_frame_vsync  in  1  frame sync, active high
- pre_frame_href  in  1  line valid
- pre_frame_de  in  1  pixel valid
- pre_rgb  in  16  RGB565 pixel
- pre_mask  in  1  threshold mask, aligned with pre_rgb
- mode  in  2  0 pass, 1 overlay, 2 blend, 3 full-screen mask
- freeze  in  1  1 = hold the displayed thumbnail
- post_frame_vsync, post_frame_href, post_frame_de  out  1 each  pre_* delayed by 2 cycles
- post_rgb  out  16  processed pixel
- frame_done  out  1  one-cycle pulse on each bank swap
- mask_count  out  clog2(NPIX+1)  count of set samples in the last swapped frame

## Operation
Counters and frame tracking:
- vs_rise = pre_frame_vsync & ~vsync_d1.
- x: +1 on each de cycle. Cleared while href is low.
- y: +1 on each href falling edge that followed at least one de. Cleared on vs_rise. Both counters saturate at H_ACT / V_ACT.
- armed: set by the first vs_rise after reset. While armed=0, no writes and no swaps occur.

Write path:
- Sample condition: armed & de & x<H_ACT & y<V_ACT & x%DECIM==DECIM-1 & y%DECIM==DECIM-1.
- Write address = wbank*NPIX + (y/DECIM)*TW + x/DECIM. It is computed from the counters, never incremented.
- Each sample with pre_mask=1 increments accum.

Bank swap on vs_rise:
- Frame complete means y==V_ACT at the edge.
- Complete and freeze=0: swap rbank and wbank, latch mask_count<=accum, set valid<=1, pulse frame_done.
- Incomplete, or freeze=1: no swap, mask_count held. The next frame overwrites wbank.
- In every case, accum clears on vs_rise.
- rbank != wbank always, so a read and a write never touch the same bank.

Read and mux:
- Overlay region: OX<=x<OX+TW and OY<=y<OY+TH.
- Read address = rbank*NPIX + (y-OY)*TW + (x-OX). The RAM has a registered read of 1 cycle.
- mode is latched on vs_rise and is constant for the whole frame.
- mode 0: post_rgb = pre_rgb.
- mode 1: in region with valid=1, output bit ? FG_COLOR : BG_COLOR. Otherwise pre_rgb.
- mode 2: in region with valid=1, output bit ? FG_COLOR : {r>>1, g>>1, b>>1} of pre_rgb. Otherwise pre_rgb.
- mode 3: full screen, pre_mask ? FG_COLOR : BG_COLOR. The buffer is unused.

## Timing
- Latency is exactly 2 cycles for every post_* output, in every mode, including while invalid.
- Stage 1 registers the address and delays rgb/mask/sync. Stage 2 performs the mux.
- frame_done is asserted in the cycle after the clk edge that samples vs_rise. mask_count updates in the same cycle.
- Reset values: all outputs 0; x=y=0, wbank=0, rbank=1, valid=0, armed=0, accum=0, latched mode=0.
- RAM contents are not cleared by reset.
- Reset mid-frame: the rest of that frame is ignored, and writing resumes after the next vs_rise.
- de while href is low is ignored.
- Simultaneous vs_rise and de: the vsync action takes priority, and the pixel counts as x=0 of the new frame's first line.

## Test plan
Common parameters: H_ACT=16, V_ACT=8, DECIM=2, OX=4, OY=2, so TW=8 and TH=4.

1. Reset, then two complete frames with mask all 1 and mode=1 → frame 1 output equals pre_rgb delayed 2 with no frame_done. At the vsync after the armed frame: one frame_done, mask_count=32.
2. Frame with mask=1 only at even x → mask_count=0 after the swap. Next frame, pixel (4,2) = BG_COLOR, pixel (3,2) = pre_rgb.
3. Blend: stored bit 0, mode=2, pre_rgb=16'hFFFF in region → 16'h7BEF. Outside region → 16'hFFFF.
4. Truncated frame (5 lines, then vsync) → no frame_done; the overlay shows the previous thumbnail and mask_count is unchanged.
5. freeze=1 across two frames with differing masks → display and mask_count unchanged. Release freeze → swap at the next complete-frame vsync.
6. mode changed from 1 to 3 mid-frame → the change takes effect from the next frame. Mode 3 output is pre_mask ? FG_COLOR : BG_COLOR with 2-cycle latency.
